// File: rtl/psc_pkg.sv
// psc_pkg: frame definition shared by the PSC trigger link transmitter and receiver
package psc_pkg;
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL = 1'b1;
  localparam logic [7:0] DEFAULT_TRIGGER_CODE = 8'hA5;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
endpackage

// File: rtl/psc_trigger_receiver_if.sv
// psc_trigger_receiver_if: serial line in, recovered byte stream and link status out
interface psc_trigger_receiver_if;
  logic psc_input;
  logic [7:0] rx_data;
  logic rx_valid;
  logic trigger_pulse;
  logic frame_error;
  logic link_up;
  logic [15:0] error_count;
  modport master (input psc_input, output rx_data, rx_valid, trigger_pulse, frame_error, link_up, error_count);
  modport slave (output psc_input, input rx_data, rx_valid, trigger_pulse, frame_error, link_up, error_count);
endinterface

// File: rtl/psc_bit_sync.sv
// psc_bit_sync: 2-flop synchronizer resetting to idle-high, with falling-edge detect
module psc_bit_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic fall
);
  logic s1, s2, s3;
  always_ff @(posedge clk)
    if (reset) {s1, s2, s3} <= 3'b111;
    else {s1, s2, s3} <= {d, s1, s2};
  assign q = s2;
  assign fall = s3 & ~s2;
endmodule

// File: rtl/psc_trigger_receiver.sv
// psc_trigger_receiver: oversampling frame receiver with trigger decode and link health tracking
module psc_trigger_receiver
  import psc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5,
  parameter logic [7:0] TRIGGER_CODE = DEFAULT_TRIGGER_CODE,
  parameter int LINK_GOOD_FRAMES = 4,
  parameter int LINK_TIMEOUT = 100
) (
  input logic clk,
  input logic reset,
  psc_trigger_receiver_if.master bus
);
  localparam int PW = $clog2(CLKS_PER_BIT);
  localparam int SW = $clog2(LINK_TIMEOUT + 1);
  rx_state_t state, state_n;
  logic [PW-1:0] phase, phase_n;
  logic [2:0] bitcnt, bitcnt_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic line, fall, tick, good, bad, timeout;
  logic [7:0] rx_data;
  logic rx_valid, trig, ferr, link;
  logic [3:0] gcnt;
  logic [SW-1:0] sil;
  logic [15:0] errc;
  psc_bit_sync u_sync (.clk(clk), .reset(reset), .d(bus.psc_input), .q(line), .fall(fall));
  assign tick = phase == '0;
  always_comb begin
    state_n = state;
    phase_n = tick ? phase : phase - 1'b1;
    bitcnt_n = bitcnt;
    sh_n = sh;
    good = 1'b0;
    bad = 1'b0;
    case (state)
      IDLE: begin
        bitcnt_n = '0;
        if (fall) begin
          phase_n = PW'(CLKS_PER_BIT / 2);
          state_n = START;
        end
      end
      START:
        if (tick) begin
          phase_n = PW'(CLKS_PER_BIT - 1);
          state_n = line == START_LEVEL ? DATA : IDLE;
        end
      DATA:
        if (tick) begin
          sh_n = {line, sh[DATA_BITS-1:1]};
          phase_n = PW'(CLKS_PER_BIT - 1);
          bitcnt_n = bitcnt + 1'b1;
          state_n = bitcnt == 3'(DATA_BITS - 1) ? STOP : DATA;
        end
      default:
        if (tick) begin
          // leave half a bit early so a back-to-back start edge is not missed
          good = line == STOP_LEVEL;
          bad = line != STOP_LEVEL;
          state_n = IDLE;
        end
    endcase
  end
  assign timeout = sil == SW'(LINK_TIMEOUT) && !rx_valid;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      phase <= '0;
      bitcnt <= '0;
      sh <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      trig <= 1'b0;
      ferr <= 1'b0;
      gcnt <= '0;
      link <= 1'b0;
      sil <= '0;
      errc <= '0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      bitcnt <= bitcnt_n;
      sh <= sh_n;
      rx_valid <= good;
      ferr <= bad;
      trig <= good && sh == TRIGGER_CODE;
      if (good) rx_data <= sh;
      sil <= rx_valid ? '0 : sil == SW'(LINK_TIMEOUT) ? sil : sil + 1'b1;
      if (ferr || timeout) begin
        gcnt <= '0;
        link <= 1'b0;
      end else if (rx_valid) begin
        gcnt <= gcnt == 4'(LINK_GOOD_FRAMES) ? gcnt : gcnt + 4'd1;
        link <= gcnt >= 4'(LINK_GOOD_FRAMES - 1);
      end
      errc <= ferr && errc != 16'hFFFF ? errc + 16'd1 : errc;
    end
  assign bus.rx_data = rx_data;
  assign bus.rx_valid = rx_valid;
  assign bus.trigger_pulse = trig;
  assign bus.frame_error = ferr;
  assign bus.link_up = link;
  assign bus.error_count = errc;
endmodule

// File: tb/tb_psc_trigger_receiver.sv
// tb_psc_trigger_receiver: directed frames with a scoreboard of expected bytes and arrival cycles
module tb_psc_trigger_receiver;
  import psc_pkg::*;
  typedef struct {logic [7:0] d; int t;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int vcnt = 0, tcnt = 0, fcnt = 0;
  int last_v = -1, last_f = -1, rise = -1, fall = -1;
  logic prev_v = 1'b0, prev_f = 1'b0, prev_l = 1'b0;
  exp_t q[$];
  psc_trigger_receiver_if bus ();
  psc_trigger_receiver dut (.clk(clk), .reset(reset), .bus(bus));
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic stop, input bit expect_it, output int t0);
    logic [FRAME_BITS-1:0] f;
    f = {stop, d, START_LEVEL};
    t0 = cyc + 1;
    if (expect_it) q.push_back('{d, t0});
    for (int i = 0; i < FRAME_BITS; i++) begin
      bus.psc_input = f[i];
      repeat (5) @(negedge clk);
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (bus.rx_valid || bus.frame_error) chk("strobe_excl", bus.rx_valid & bus.frame_error, 0);
    if (bus.rx_valid || bus.trigger_pulse)
      chk("trig_match", bus.trigger_pulse, bus.rx_valid && bus.rx_data == 8'hA5);
    if (bus.trigger_pulse) tcnt++;
    if (bus.rx_valid) begin
      vcnt++;
      last_v = cyc;
      chk("valid_width", prev_v, 0);
      if (q.size() == 0) chk("unexpected_valid", q.size(), 1);
      else begin
        e = q.pop_front();
        chk("rx_data", bus.rx_data, e.d);
        chk("latency", cyc, e.t + 50);
      end
    end
    if (bus.frame_error) begin
      fcnt++;
      last_f = cyc;
      chk("ferr_width", prev_f, 0);
    end
    if (bus.link_up && !prev_l) rise = cyc;
    if (!bus.link_up && prev_l) fall = cyc;
    prev_v = bus.rx_valid;
    prev_f = bus.frame_error;
    prev_l = bus.link_up;
  end
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t, t4, v, n0;
    bus.psc_input = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_trigger", bus.trigger_pulse, 0);
    chk("rst_ferr", bus.frame_error, 0);
    chk("rst_link", bus.link_up, 0);
    chk("rst_errc", bus.error_count, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    send(8'h3C, 1'b1, 1'b1, t);
    drain();
    chk("n_valid_3c", vcnt, 1);
    chk("n_trig_3c", tcnt, 0);
    chk("n_ferr_3c", fcnt, 0);
    chk("hold_3c", bus.rx_data, 8'h3C);
    repeat (120) @(negedge clk);
    chk("link_idle", bus.link_up, 0);
    for (int i = 0; i < 4; i++) send(8'hA5, 1'b1, 1'b1, t4);
    drain();
    chk("n_trig_a5", tcnt, 4);
    chk("link_rise", rise, t4 + 51);
    chk("link_up_a5", bus.link_up, 1);
    send(8'h55, 1'b0, 1'b0, t);
    bus.psc_input = 1'b1;
    repeat (10) @(negedge clk);
    chk("n_ferr_bad", fcnt, 1);
    chk("ferr_time", last_f, t + 50);
    chk("errc_bad", bus.error_count, 1);
    chk("link_fall_ferr", fall, t + 51);
    chk("n_valid_bad", vcnt, 5);
    bus.psc_input = 1'b0;
    @(negedge clk);
    bus.psc_input = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_valid", vcnt, 5);
    chk("glitch_ferr", fcnt, 1);
    for (int i = 0; i < 4; i++) send(8'h5A, 1'b1, 1'b1, t);
    drain();
    chk("link_up_5a", bus.link_up, 1);
    v = last_v;
    while (cyc < v + 95) @(negedge clk);
    chk("link_before_to", bus.link_up, 1);
    while (cyc < v + 105) @(negedge clk);
    chk("link_after_to", bus.link_up, 0);
    send(8'hC3, 1'b1, 1'b1, t);
    drain();
    chk("link_one_good", bus.link_up, 0);
    for (int i = 0; i < 3; i++) send(8'h0F, 1'b1, 1'b1, t);
    drain();
    chk("link_relock", bus.link_up, 1);
    fork
      send(8'h00, 1'b1, 1'b0, t);
      begin
        repeat (25) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_data", bus.rx_data, 0);
        chk("mid_rst_link", bus.link_up, 0);
        chk("mid_rst_errc", bus.error_count, 0);
        chk("mid_rst_valid", bus.rx_valid, 0);
      end
    join
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    n0 = vcnt;
    send(8'h81, 1'b1, 1'b1, t);
    drain();
    chk("post_rst_count", vcnt, n0 + 1);
    chk("post_rst_data", bus.rx_data, 8'h81);
    chk("post_rst_errc", bus.error_count, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
